aes_ct_serializer: RTL and testbench
====================================

// Module: aes_ct_serializer
// PURPOSE
//   Downstream consumer of the AES core's result: captures each 128-bit block
//   on the core's output-valid strobe into a small FIFO. Streams each block out
//   as OUT_W-bit beats, most-significant beat first, over a valid/ready
//   handshake toward a byte-wide sink (UART or trace port).
//   Flags ciphertext lost to backpressure.
// PARAMETERS
//   DATA_W  128  width of the AES result block
//   OUT_W   8    beat width; DATA_W % OUT_W == 0 is required
//   DEPTH   2    number of whole blocks buffered (>= 1)
// PORTS
//   AES_clk             in   1              sole clock, rising edge
//   AES_rst             in   1              synchronous, active-high reset
//   AES_data_out_valid  in   1              core result strobe, one cycle per block
//   AES_data_out        in   DATA_W         core result, sampled when valid=1
//   ser_clear           in   1              sync clear of ser_overflow only
//   ser_data            out  OUT_W          current beat
//   ser_valid           out  1              ser_data holds a beat
//   ser_ready           in   1              sink accepts the beat this cycle
//   ser_last            out  1              current beat is the block's final beat
//   ser_overflow        out  1              sticky: a block was dropped
//   ser_level           out  $clog2(DEPTH+1)  blocks held, including the one in flight
// BEHAVIOUR
//   Clock and reset: one clock domain. AES_rst=1 at a rising edge has this effect:
//     - FIFO pointers, level, beat counter and overflow clear.
//     - All outputs read 0 next cycle.
//     - Any in-flight block is discarded.
//     - A valid strobe in the same cycle as reset is ignored.
//   Beat count: BEATS = DATA_W/OUT_W (16 by default). Beat counter bcnt runs 0..BEATS-1.
//   Output state machine:
//     - IDLE (level==0): ser_valid=0.
//     - SEND (level>0): ser_valid=1 and ser_data = head[DATA_W-1-bcnt*OUT_W -: OUT_W].
//     - ser_last = SEND && bcnt==BEATS-1.
//   Beat handshake (ser_valid && ser_ready):
//     - Not the last beat: bcnt increments.
//     - Last beat: bcnt returns to 0, the head pops, and the FSM returns to IDLE if level becomes 0.
//   Output stability: while ser_valid=1 and ser_ready=0, ser_data and ser_last hold stable.
//   No combinational path from ser_ready to any output. All outputs come from registers
//   (head entry, bcnt, pointers).
//   Push: push = AES_data_out_valid && (level<DEPTH || pop). The same edge writes the tail
//   and advances the tail pointer.
//   Latency:
//     - Strobe at edge t into an empty FIFO: ser_valid=1 with beat 0 after edge t.
//     - A full block drains in BEATS cycles if ser_ready is held high.
//   Simultaneous push and pop:
//     - Level is unchanged.
//     - When full, this push is accepted, because the slot frees on the same edge.
//   Overflow:
//     - Strobe with level==DEPTH and no pop in that cycle: the block is dropped and
//       ser_overflow goes to 1.
//     - Existing contents are untouched.
//   Clearing overflow:
//     - ser_overflow clears only on AES_rst, or on ser_clear with no new overflow that cycle.
//     - A new overflow in the same cycle as ser_clear wins: the flag stays at 1.
//   Pointer wrap: pointers wrap modulo DEPTH. Level stays in 0..DEPTH.
//   Valid strobe held high: each high cycle is a separate block. The upstream core pulses
//   it for one cycle.
// TESTING
//   1. Reset:
//      - Stimulus: AES_rst=1 for 2 cycles, random inputs.
//      - Required: ser_valid/ser_last/ser_overflow=0, ser_level=0, ser_data=0.
//   2. Single block:
//      - Stimulus: strobe 128'h3925841d_02dc09fb_dc118597_196a0b32, ser_ready=1.
//      - Required: bytes 39,25,84,1d,...,0b,32 on 16 consecutive cycles starting
//        1 cycle after the strobe.
//      - Required: ser_last only on byte 32; then ser_valid=0 and level=0.
//   3. Backpressure:
//      - Stimulus: same block, ser_ready toggled 1,0,0,1,...
//      - Required: bytes in order, none skipped or repeated.
//      - Required: ser_data stable during every ready=0 cycle.
//   4. Fill and overflow (DEPTH=2):
//      - Stimulus: ser_ready=0, three strobes (blocks A, B, C).
//      - Required: level=2 and ser_overflow=1 after C.
//      - Required: on release, A then B stream out; C never appears.
//   5. Push on final pop:
//      - Stimulus: full FIFO; strobe C in the same cycle the last byte of A is accepted.
//      - Required: C accepted, level stays 2, no overflow.
//      - Required: output order A, B, C.
//   6. Clear and mid-block reset:
//      - Stimulus: ser_clear clears the flag. Then AES_rst at beat 7 of a block,
//        followed by a new strobe D.
//      - Required: after reset, outputs are 0. D's beat 0 appears 1 cycle after its strobe.

Source files
------------

// File: rtl/aes_ct_serializer.sv
`default_nettype none
// ============================================================================
// Module      : aes_ct_serializer
// Description : Captures each AES result block on the core's output-valid
//               strobe into a small block FIFO and streams the head block out
//               as OUT_W-bit beats, most-significant beat first, over a
//               valid/ready handshake. A sticky flag records blocks dropped
//               because the FIFO was full.
// Ports       :
//   AES_clk            in   sole clock, rising edge
//   AES_rst            in   synchronous active-high reset
//   AES_data_out_valid in   one-cycle strobe per result block
//   AES_data_out       in   result block, sampled with the strobe
//   ser_clear          in   clears ser_overflow (a same-cycle drop wins)
//   ser_data           out  current beat (0 when idle)
//   ser_valid          out  ser_data holds a beat
//   ser_ready          in   sink accepts the beat this cycle
//   ser_last           out  current beat is the final beat of its block
//   ser_overflow       out  sticky: at least one block was dropped
//   ser_level          out  blocks held, including the one being sent
// Revision    : 1.0 - initial release
// ============================================================================
module aes_ct_serializer #(
  parameter int DATA_W = 128,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       AES_clk,
  input  logic                       AES_rst,
  input  logic                       AES_data_out_valid,
  input  logic [DATA_W-1:0]          AES_data_out,
  input  logic                       ser_clear,
  output logic [OUT_W-1:0]           ser_data,
  output logic                       ser_valid,
  input  logic                       ser_ready,
  output logic                       ser_last,
  output logic                       ser_overflow,
  output logic [$clog2(DEPTH+1)-1:0] ser_level
);

  localparam int BEATS  = DATA_W / OUT_W;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [LVL_W-1:0]  C_DEPTH     = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  C_LVL_ONE   = LVL_W'(1);
  localparam logic [PTR_W-1:0]  C_PTR_MAX   = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  C_PTR_ONE   = PTR_W'(1);
  localparam logic [BCNT_W-1:0] C_LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [BCNT_W-1:0] C_BCNT_ONE  = BCNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic last_beat;
  logic beat_hs;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    last_beat = (bcnt_q == C_LAST_BEAT);
    beat_hs   = (state_q == ST_SEND) && ser_ready;
    pop       = beat_hs && last_beat;
    // A full FIFO still accepts a block when the head leaves on the same edge.
    push      = AES_data_out_valid && ((level_q != C_DEPTH) || pop);
    drop      = AES_data_out_valid && (level_q == C_DEPTH) && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    bcnt_d   = bcnt_q;
    ovf_d    = ovf_q;

    if (beat_hs) begin
      bcnt_d = last_beat ? '0 : (bcnt_q + C_BCNT_ONE);
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == C_PTR_MAX) ? '0 : (rd_ptr_q + C_PTR_ONE);
    end

    if (push) begin
      wr_ptr_d = (wr_ptr_q == C_PTR_MAX) ? '0 : (wr_ptr_q + C_PTR_ONE);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + C_LVL_ONE;
      2'b01:   level_d = level_q - C_LVL_ONE;
      default: level_d = level_q;
    endcase

    // A fresh drop outranks a clear request in the same cycle.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ser_clear) begin
      ovf_d = 1'b0;
    end

    state_d = (level_d != '0) ? ST_SEND : ST_IDLE;
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      bcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      bcnt_q   <= bcnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Block storage carries no reset; validity is tracked by the level count.
  always_ff @(posedge AES_clk) begin
    if (!AES_rst && push) begin
      mem_q[wr_ptr_q] <= AES_data_out;
    end
  end

  // Outputs are decoded purely from registered state, so ser_ready never
  // reaches them combinationally and they hold steady while stalled.
  always_comb begin
    ser_valid = (state_q == ST_SEND);
    ser_last  = (state_q == ST_SEND) && last_beat;
    ser_data  = '0;
    if (state_q == ST_SEND) begin
      ser_data = mem_q[rd_ptr_q][DATA_W - 1 - OUT_W * int'(bcnt_q) -: OUT_W];
    end
  end

  assign ser_overflow = ovf_q;
  assign ser_level    = level_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_ct_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_ct_serializer
// Description : Self-checking bench for aes_ct_serializer. A queue-of-blocks
//               reference model predicts every output each cycle; directed
//               scenarios also check the received byte stream against
//               known block contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_ct_serializer;

  localparam int DATA_W = 128;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 2;
  localparam int BEATS  = DATA_W / OUT_W;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              strobe;
  logic [DATA_W-1:0] din;
  logic              clr;
  logic [OUT_W-1:0]  ser_data;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_last;
  logic              ser_overflow;
  logic [LVL_W-1:0]  ser_level;

  always #5 clk = ~clk;

  aes_ct_serializer #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .DEPTH  (DEPTH)
  ) dut (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .AES_data_out_valid (strobe),
    .AES_data_out       (din),
    .ser_clear          (clr),
    .ser_data           (ser_data),
    .ser_valid          (ser_valid),
    .ser_ready          (ser_ready),
    .ser_last           (ser_last),
    .ser_overflow       (ser_overflow),
    .ser_level          (ser_level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: blocks held, index of the beat on offer, sticky flag.
  logic [DATA_W-1:0] mq[$];
  int                m_beat = 0;
  bit                m_ovf  = 1'b0;

  // Bytes the DUT handed over (valid && ready seen before an edge).
  logic [7:0] rx[$];

  localparam logic [127:0] K  = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] BA = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BB = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
  localparam logic [127:0] BC = 128'hdeadbeef_cafef00d_13579bdf_2468ace0;
  localparam logic [127:0] BX = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;

  function automatic logic [7:0] beat_of(input logic [127:0] b, input int i);
    logic [127:0] t;
    t = b;
    return t[127 - 8 * i -: 8];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs driven before it.
  task automatic model_edge();
    int sz;
    bit hs, pop, push, newovf;
    if (rst) begin
      mq.delete();
      m_beat = 0;
      m_ovf  = 1'b0;
      return;
    end
    sz     = mq.size();
    hs     = (sz > 0) && ser_ready;
    pop    = hs && (m_beat == BEATS - 1);
    push   = strobe && ((sz < DEPTH) || pop);
    newovf = strobe && (sz == DEPTH) && !pop;
    if (hs) begin
      if (pop) begin
        void'(mq.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (push) mq.push_back(din);
    if (newovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic cycle();
    bit         stall, was_rst;
    logic [7:0] d;
    logic       l;
    bit         ev;
    if (ser_valid === 1'b1 && ser_ready === 1'b1) rx.push_back(ser_data);
    stall   = (ser_valid === 1'b1) && (ser_ready === 1'b0);
    was_rst = rst;
    d       = ser_data;
    l       = ser_last;
    @(posedge clk);
    model_edge();
    #1;
    if (stall && !was_rst) begin
      chk("hold_data", ser_data, d);
      chk("hold_last", ser_last, l);
    end
    ev = (mq.size() > 0);
    chk("valid", ser_valid, ev);
    chk("data", ser_data, ev ? beat_of(mq[0], m_beat) : 8'h00);
    chk("last", ser_last, ev && (m_beat == BEATS - 1));
    chk("level", ser_level, mq.size());
    chk("overflow", ser_overflow, m_ovf);
  endtask

  task automatic chk_rx(input string tag, input logic [127:0] b, input int base);
    for (int i = 0; i < BEATS; i++) begin
      chk(tag, (rx.size() > base + i) ? rx[base + i] : 8'hxx, beat_of(b, i));
    end
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; din = '0; clr = 1'b0; ser_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      strobe    = 1'($urandom);
      din       = {$urandom, $urandom, $urandom, $urandom};
      clr       = 1'($urandom);
      ser_ready = 1'($urandom);
      cycle();
    end
    chk("rst_valid", ser_valid, 1'b0);
    chk("rst_level", ser_level, 0);
    chk("rst_data", ser_data, 8'h00);
    rst = 1'b0; strobe = 1'b0; clr = 1'b0; ser_ready = 1'b1;
    cycle();

    // Single block, sink always ready
    rx.delete();
    strobe = 1'b1; din = K;
    cycle();
    strobe = 1'b0;
    chk("single_first_beat", ser_data, 8'h39);
    chk("single_first_valid", ser_valid, 1'b1);
    repeat (BEATS) cycle();
    chk("single_count", rx.size(), BEATS);
    chk_rx("single_bytes", K, 0);
    chk("single_idle", ser_valid, 1'b0);
    chk("single_level", ser_level, 0);

    // Backpressure 1,0,0,1,0,0,...
    rx.delete();
    strobe = 1'b1; din = K;
    cycle();
    strobe = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rx.size() >= BEATS) break;
      ser_ready = (i % 3 == 0);
      cycle();
    end
    chk("bp_count", rx.size(), BEATS);
    chk_rx("bp_bytes", K, 0);
    ser_ready = 1'b1;
    cycle();

    // Fill and overflow
    rx.delete();
    ser_ready = 1'b0;
    strobe = 1'b1; din = BA; cycle();
    strobe = 1'b0;           cycle();
    strobe = 1'b1; din = BB; cycle();
    strobe = 1'b1; din = BC; cycle();
    strobe = 1'b0;
    chk("ovf_level", ser_level, 2);
    chk("ovf_flag", ser_overflow, 1'b1);
    ser_ready = 1'b1;
    repeat (2 * BEATS + 2) cycle();
    chk("ovf_count", rx.size(), 2 * BEATS);
    chk_rx("ovf_a", BA, 0);
    chk_rx("ovf_b", BB, BEATS);

    // Clear vs new drop, then push on the final pop
    rx.delete();
    ser_ready = 1'b0;
    strobe = 1'b1; din = BA; cycle();
    strobe = 1'b1; din = BB; cycle();
    strobe = 1'b1; din = BX; clr = 1'b1; cycle();
    chk("clear_loses_to_drop", ser_overflow, 1'b1);
    strobe = 1'b0; clr = 1'b1; cycle();
    clr = 1'b0;
    chk("clear_flag", ser_overflow, 1'b0);
    ser_ready = 1'b1;
    repeat (BEATS - 1) cycle();
    chk("final_beat_last", ser_last, 1'b1);
    strobe = 1'b1; din = BC; cycle();
    strobe = 1'b0;
    chk("pushpop_level", ser_level, 2);
    chk("pushpop_ovf", ser_overflow, 1'b0);
    repeat (2 * BEATS + 2) cycle();
    chk("pushpop_count", rx.size(), 3 * BEATS);
    chk_rx("pushpop_a", BA, 0);
    chk_rx("pushpop_b", BB, BEATS);
    chk_rx("pushpop_c", BC, 2 * BEATS);

    // Mid-block reset, strobe during reset ignored, then new block D
    ser_ready = 1'b1;
    strobe = 1'b1; din = BB; cycle();
    strobe = 1'b0;
    repeat (7) cycle();
    chk("mid_beat7", ser_data, beat_of(BB, 7));
    rst = 1'b1; strobe = 1'b1; din = BX; cycle();
    rst = 1'b0; strobe = 1'b0;
    chk("mid_rst_valid", ser_valid, 1'b0);
    chk("mid_rst_data", ser_data, 8'h00);
    chk("mid_rst_level", ser_level, 0);
    strobe = 1'b1; din = BC; cycle();
    strobe = 1'b0;
    chk("d_first_valid", ser_valid, 1'b1);
    chk("d_first_beat", ser_data, 8'hde);
    repeat (BEATS + 1) cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(399) == 0);
      strobe    = ($urandom_range(7) == 0);
      din       = {$urandom, $urandom, $urandom, $urandom};
      ser_ready = ($urandom_range(3) != 0);
      clr       = ($urandom_range(39) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
